// File: rtl/dr_scan_pkg.sv
// Shared types and dual-rail coding helpers for the scan-chain controller.
package dr_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SH_TOK,
    SH_SPC,
    CAP_TOK,
    CAP_SPC
  } state_t;

  localparam logic [1:0] DR_ONE  = 2'b10;
  localparam logic [1:0] DR_ZERO = 2'b01;

  // Spacer codeword for the given polarity: {0,0} or {1,1}.
  function automatic logic [1:0] dr_spacer(input logic pol);
    return {pol, pol};
  endfunction

  // A codeword is a valid token only when the two rails differ.
  function automatic logic dr_valid(input logic [1:0] code);
    return code[1] ^ code[0];
  endfunction

endpackage

// File: rtl/dr_tok_enc.sv
// Combinational encoder: a bit becomes a dual-rail token, or a spacer when idle.
module dr_tok_enc
  import dr_scan_pkg::*;
(
  input  logic       tok,
  input  logic       bit_val,
  input  logic       pol,
  output logic [1:0] code
);

  // Token selects the rail pair for bit_val; otherwise the spacer is emitted.
  always_comb begin
    code = dr_spacer(pol);
    if (tok) code = bit_val ? DR_ONE : DR_ZERO;
  end

endmodule

// File: rtl/dr_scan_ctrl.sv
// Dual-rail scan-chain controller: serial shift of a test vector with
// token/spacer alternation, parallel scan-out capture and optional capture.
module dr_scan_ctrl
  import dr_scan_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 16,
  parameter bit          SP_POL    = 1'b0
) (
  input  logic                 C,
  input  logic                 RN,
  input  logic                 start,
  input  logic                 cap_en,
  input  logic [CHAIN_LEN-1:0] vec_in,
  output logic [CHAIN_LEN-1:0] vec_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 SE_1,
  output logic                 SE_0,
  output logic                 SD_1,
  output logic                 SD_0,
  input  logic                 SO_1,
  input  logic                 SO_0,
  output logic                 SP
);

  localparam int unsigned KW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(CHAIN_LEN - 1);

  state_t                 state, nxt;
  logic [KW-1:0]          k;
  logic [CHAIN_LEN-1:0]   vec_q;
  logic                   cap_q;
  logic                   done_nxt;
  logic                   accept;
  logic                   se_tok, se_scan, sd_tok;
  logic [1:0]             se_code, sd_code, so_code;

  assign accept  = (state == IDLE) && start;
  assign so_code = {SO_1, SO_0};
  assign busy    = (state != IDLE);
  assign SP      = SP_POL;

  // State, index counter, latched request and result registers.
  always_ff @(posedge C) begin
    if (!RN) begin
      state   <= IDLE;
      k       <= '0;
      vec_q   <= '0;
      cap_q   <= 1'b0;
      vec_out <= '0;
      err     <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= nxt;
      done  <= done_nxt;
      if (accept) begin
        vec_q <= vec_in;
        cap_q <= cap_en;
        err   <= 1'b0;
        k     <= '0;
      end
      if (state == SH_TOK) begin
        vec_out[k] <= dr_valid(so_code) ? SO_1 : 1'b0;
        if (!dr_valid(so_code)) err <= 1'b1;
      end
      if (state == SH_SPC && k != K_LAST) k <= k + 1'b1;
    end
  end

  // Next-state decode and dual-rail drive selection.
  always_comb begin
    nxt      = state;
    done_nxt = 1'b0;
    se_tok   = 1'b0;
    se_scan  = 1'b0;
    sd_tok   = 1'b0;
    case (state)
      IDLE: if (start) nxt = SH_TOK;
      SH_TOK: begin
        se_tok  = 1'b1;
        se_scan = 1'b1;
        sd_tok  = 1'b1;
        nxt     = SH_SPC;
      end
      SH_SPC: begin
        if (k != K_LAST) begin
          nxt = SH_TOK;
        end else if (cap_q) begin
          nxt = CAP_TOK;
        end else begin
          nxt      = IDLE;
          done_nxt = 1'b1;
        end
      end
      CAP_TOK: begin
        se_tok = 1'b1;
        nxt    = CAP_SPC;
      end
      CAP_SPC: begin
        nxt      = IDLE;
        done_nxt = 1'b1;
      end
      default: nxt = IDLE;
    endcase
  end

  dr_tok_enc u_se_enc (
    .tok     (se_tok),
    .bit_val (se_scan),
    .pol     (SP_POL),
    .code    (se_code)
  );

  dr_tok_enc u_sd_enc (
    .tok     (sd_tok),
    .bit_val (vec_q[k]),
    .pol     (SP_POL),
    .code    (sd_code)
  );

  assign {SE_1, SE_0} = se_code;
  assign {SD_1, SD_0} = sd_code;

endmodule

// File: doc/dr_scan_ctrl.md
# dr_scan_ctrl

Dual-rail scan-chain controller that drives the scan side of a chain of dual-rail multiplexed-scan flip-flops (DFS/DFSC/DFSP/DFSCP `_0dr` family). It serialises a parallel test vector into the chain as dual-rail tokens, alternating each token with a spacer. It deserialises the chain's scan-out into a parallel result and optionally performs one functional capture between shift passes. The block sits between the test access logic and the first/last flop of the chain.

## Interface
- `CHAIN_LEN`, default 16: number of flops in the chain; must be ≥ 1.
- `SP_POL`, default 0: spacer polarity. 0 = all-zero spacer {0,0}; 1 = all-one spacer {1,1}.
- `C` in 1: clock, the only clock.
- `RN` in 1: reset, synchronous, active-low.
- `start` in 1: request an operation; sampled only in IDLE.
- `cap_en` in 1: sampled with `start`; 1 = insert one capture token after shifting.
- `vec_in` in CHAIN_LEN: vector to shift in; latched on `start` acceptance.
- `vec_out` out CHAIN_LEN: scan-out result; valid when `done`=1, held until the next acceptance.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: sticky invalid-codeword flag for the current/last operation.
- `SE_1`, `SE_0` out 1 each: dual-rail scan enable to the chain.
- `SD_1`, `SD_0` out 1 each: dual-rail scan data to the first flop.
- `SO_1`, `SO_0` in 1 each: dual-rail Q of the last flop.
- `SP` out 1: spacer polarity to the chain; constant `SP_POL`.

## Operation
- Encoding: logic 1 = (1,0), logic 0 = (0,1), spacer = (SP_POL,SP_POL).
- States: IDLE, SH_TOK, SH_SPC, CAP_TOK, CAP_SPC.
- IDLE with `start`=1: latch `vec_in` and `cap_en`, clear `err`, set token index k=0, go to SH_TOK.
- In IDLE, SE and SD drive spacer.
- SH_TOK:
  - SE = (1,0) and SD = code(`vec_in`[k]).
  - Sample SO on the closing edge. A valid code is stored into `vec_out`[k]. An invalid code, (0,0) or (1,1), stores 0 and sets `err`.
  - Then go to SH_SPC.
- SH_SPC:
  - SE and SD drive spacer; SO is ignored.
  - If k = CHAIN_LEN-1, go to CAP_TOK when `cap_en` was latched, else to IDLE with `done`.
  - Otherwise increment k and go to SH_TOK.
- CAP_TOK: SE = (0,1), selecting the functional D input; SD = spacer; SO is ignored.
- CAP_SPC: all outputs spacer; then go to IDLE with `done`.
- FIFO property: with no capture in between, `vec_out` of a run equals `vec_in` of the preceding run. `vec_in`[0] leaves the chain first.
- `start` while `busy`=1 is ignored. Changes to `vec_in`/`cap_en` after acceptance have no effect.
- Counter width is $clog2(CHAIN_LEN). k never exceeds CHAIN_LEN-1 and wraps only by returning to IDLE.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `vec_out`=0, SE=SD=spacer, `SP`=SP_POL, state IDLE.
- Acceptance edge is t0. Token k occupies cycle 1+2k, its spacer occupies cycle 2+2k, and `busy`=1 from cycle 1.
- Without capture: `done`=1 and `busy`=0 in cycle 2·CHAIN_LEN+1.
- With capture: capture token in cycle 2·CHAIN_LEN+1, spacer in 2·CHAIN_LEN+2, `done` in 2·CHAIN_LEN+3.
- `done` lasts exactly one cycle. `vec_out` and `err` are final in that cycle.
- `start`=1 during the `done` cycle is accepted, so a back-to-back run begins with `busy` re-asserted in the next cycle.
- SE/SD never switch directly between two token values; a spacer cycle always intervenes.
- `RN`=0 at any point, including mid-shift: the next cycle shows reset values, no `done` is produced, and the partial `vec_out` is discarded (cleared).

## Structure
- Package `dr_scan_pkg`:
  - state enum;
  - localparams `DR_ONE`=2'b10, `DR_ZERO`=2'b01;
  - function `dr_spacer(pol)`;
  - function `dr_valid(code)`.
- Sub-module `dr_tok_enc`: combinational bit/spacer to dual-rail encoder, instantiated once for SD and once for SE.
- Everything else lives in the top-level FSM plus the index counter and output registers.

## Test plan
All scenarios use CHAIN_LEN=4, SP_POL=0, and a behavioural chain model of four DFS flops.
- Reset: hold `RN`=0 for 2 cycles → SE=SD=00, `SP`=0, `busy`=0, `done`=0, `vec_out`=0.
- Shift only:
  - Run 1: `vec_in`=4'b0110, `cap_en`=0 → `done` at cycle 9.
  - Run 2: `vec_in`=4'b1001 → `vec_out`=4'b0110, `err`=0.
  - Every even cycle during both runs shows SE=SD=00.
- Capture: shift in 4'b0000 with `cap_en`=1 and chain D inputs tied to 4'b1011 → `done` at cycle 11; SE=(0,1) in cycle 9; the next shift run returns 4'b1011.
- Invalid SO: force SO=(1,1) in cycle 5 (token 2) → `err`=1 at `done` and `vec_out`[2]=0; the next accepted `start` clears `err` in cycle 1.
- Handshake:
  - `start` pulsed at cycle 4 is ignored, so `done` still arrives at cycle 9.
  - `start` held through the `done` cycle → `busy`=1 in cycle 10 and the second `done` at cycle 18.
- Mid-op reset: `RN`=0 in cycle 5 → cycle 6 shows `busy`=0, SE=SD=00, `vec_out`=0, and no `done` is ever pulsed for that run.
